button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects the one-cycle `rise` pulses from the per-arrow debouncers and tags each with a timestamp from a free-running tick counter. It then hands the events, one at a time, to the game-logic consumer over a valid/ready handshake. Round-robin arbitration keeps simultaneous presses fair. The block holds one pending event per lane and counts presses lost to backpressure. It sits between the debouncer bank and the scoring FSM.

## Interface
- `NUM_LANES`, 4, number of button lanes (≥2)
- `STAMP_BITS`, 16, width of timestamp counter and `evt_stamp`
- `LANE_BITS`, `$clog2(NUM_LANES)`, derived, not overridden
- `clock` in 1: the single clock; all logic on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `rise` in NUM_LANES: per-lane one-cycle press pulses, synchronous to `clock`
- `tick` in 1: one-cycle timestamp strobe (e.g. 1 kHz)
- `clear_drops` in 1: synchronous clear of `drop_count`
- `evt_ready` in 1: consumer accepts event
- `evt_valid` out 1: event presented
- `evt_lane` out LANE_BITS: lane index of presented event
- `evt_stamp` out STAMP_BITS: timestamp captured when press arrived
- `drop_count` out 8: saturating count of dropped presses

## Operation
- **Reset.** On `reset_n` low, all of the following take effect immediately, with no clock edge needed:
  - `evt_valid`=0, `evt_lane`=0, `evt_stamp`=0, `drop_count`=0.
  - pending[]=0, per-lane stamps=0, stamp counter=0, rr pointer=NUM_LANES-1.
  - Reset asserted mid-handshake discards the presented event and all pending events.
- **Stamp counter.**
  - +1 on each edge with `tick`=1; wraps modulo 2^STAMP_BITS.
  - Captures use the pre-increment value.
- **Pending capture.** For each lane i with `rise[i]`=1 at an edge:
  - If pending[i]=0, or lane i is being moved to the output at this edge: set pending[i]=1 and stamp[i] = current counter.
  - Otherwise the press is dropped. pending[i] and stamp[i] keep their original values.
- **Drops.**
  - `drop_count` += number of lanes dropped this edge, saturating at 255.
  - `clear_drops`=1 forces 0 and takes priority; drops on that same edge are not counted.
- **Output register, two states:**
  - EMPTY (`evt_valid`=0): if any pending bit is set, load the winner, clear its pending bit, and go to FULL. Otherwise stay.
  - FULL (`evt_valid`=1): `evt_lane` and `evt_stamp` are held stable.
    - On `evt_valid`&&`evt_ready` with any pending bit set: load the next winner at the same edge and stay FULL.
    - On `evt_valid`&&`evt_ready` with nothing pending: go to EMPTY.
- **Arbitration.**
  - Search order is ptr+1, ptr+2, …, wrapping modulo NUM_LANES.
  - The first pending lane wins; ptr becomes the winner's index.
  - Winner selection uses the pending register only; `rise` on the same edge is not visible to it.

## Timing
- A `rise` sampled at edge E0 sets pending after E0. If the output is EMPTY, `evt_valid`=1 after E1, a latency of 2 edges.
- Throughput is 1 event per cycle while `evt_ready`=1 and events are pending.
- `evt_valid` never deasserts without acceptance. Lane and stamp must not change while valid and not ready.
- `evt_ready` may be high while `evt_valid`=0; this has no effect.
- A `rise` on the lane leaving pending at the same edge re-arms that lane and is not a drop. The new event is presented after the current one.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset mid-operation.**
  - Stimulus: drop_count=3, valid high, 2 lanes pending; pulse `reset_n` low between edges.
  - Required: all outputs 0 immediately. After release, no event appears without new `rise`.
- **Single event.**
  - Stimulus: counter=5, `rise`=4'b0100, `evt_ready`=1.
  - Required: `evt_valid`=1 two edges later with lane=2, stamp=5, high for exactly 1 cycle.
- **Round robin.**
  - Stimulus: press lane 1 alone and accept it. Then `rise`=4'b1101 on one edge, `evt_ready`=1.
  - Required: lanes 2, 3, 0 on consecutive cycles.
- **Backpressure and drop.**
  - Stimulus: `evt_ready`=0; lane 1 rises at counters 7, 9 and 12.
  - Required: first event presented stable with stamp 7. Second press pending with stamp 9; third press dropped, drop_count=1.
  - Then `evt_ready`=1: stamp 7, then stamp 9.
- **Saturation and clear.**
  - Stimulus: 300 drops.
  - Required: drop_count=255. `clear_drops` with a simultaneous drop gives 0.
- **Re-arm and wrap.**
  - Stimulus: `rise[3]` on the edge lane 3 is loaded.
  - Required: two lane-3 events, drop_count unchanged.
  - Stimulus: 65536 ticks.
  - Required: counter reads 0; the next event stamp is 0.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: timestamps per-lane press pulses, holds one pending
// event per lane, and presents them one at a time over valid/ready using a
// round-robin search. Presses that find their lane occupied are counted in a
// saturating drop counter.
module button_event_arbiter #(
  parameter  int unsigned NUM_LANES  = 4,
  parameter  int unsigned STAMP_BITS = 16,
  localparam int unsigned LANE_BITS  = $clog2(NUM_LANES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_LANES-1:0]  rise,
  input  logic                  tick,
  input  logic                  clear_drops,
  input  logic                  evt_ready,
  output logic                  evt_valid,
  output logic [LANE_BITS-1:0]  evt_lane,
  output logic [STAMP_BITS-1:0] evt_stamp,
  output logic [7:0]            drop_count
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                state;
  logic [STAMP_BITS-1:0] stamp_cnt;
  logic [NUM_LANES-1:0]  pending;
  logic [STAMP_BITS-1:0] lane_stamp [NUM_LANES];
  logic [LANE_BITS-1:0]  rr_ptr;

  logic                  load;
  logic [LANE_BITS-1:0]  winner;
  logic [NUM_LANES-1:0]  take;
  logic [NUM_LANES-1:0]  drop_vec;
  logic [LANE_BITS:0]    n_drops;
  int unsigned           drop_sum;

  // Round-robin winner: first pending lane after the last winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = rr_ptr;
    for (int unsigned off = 1; off <= NUM_LANES; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_LANES;
      if (!found && pending[idx]) begin
        winner = LANE_BITS'(idx);
        found  = 1'b1;
      end
    end
  end

  // An event moves to the output when EMPTY, or when FULL and accepted.
  always_comb begin
    load = (|pending) && ((state == S_EMPTY) || evt_ready);
  end

  // Capture vs. drop per lane; a lane leaving pending this edge can re-arm.
  always_comb begin
    take     = '0;
    drop_vec = '0;
    n_drops  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      take[i]     = rise[i] && (!pending[i] || (load && (winner == LANE_BITS'(i))));
      drop_vec[i] = rise[i] && !take[i];
      n_drops     = n_drops + (LANE_BITS+1)'(drop_vec[i]);
    end
    drop_sum = 32'(drop_count) + 32'(n_drops);
  end

  // Free-running timestamp counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stamp_cnt <= '0;
    end else if (tick) begin
      stamp_cnt <= stamp_cnt + 1'b1;
    end
  end

  // Pending bits and per-lane stamps; a re-arm overrides the clear below it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) lane_stamp[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (load && (winner == LANE_BITS'(i))) pending[i] <= 1'b0;
        if (take[i]) begin
          pending[i]    <= 1'b1;
          lane_stamp[i] <= stamp_cnt;
        end
      end
    end
  end

  // Saturating drop counter with synchronous clear taking priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (clear_drops) begin
      drop_count <= '0;
    end else begin
      drop_count <= (drop_sum > 255) ? 8'd255 : drop_sum[7:0];
    end
  end

  // Output register FSM with registered valid/lane/stamp and rr pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_EMPTY;
      evt_valid <= 1'b0;
      evt_lane  <= '0;
      evt_stamp <= '0;
      rr_ptr    <= LANE_BITS'(NUM_LANES - 1);
    end else begin
      case (state)
        S_EMPTY: begin
          if (load) begin
            state     <= S_FULL;
            evt_valid <= 1'b1;
            evt_lane  <= winner;
            evt_stamp <= lane_stamp[winner];
            rr_ptr    <= winner;
          end
        end
        S_FULL: begin
          if (evt_ready) begin
            if (load) begin
              evt_lane  <= winner;
              evt_stamp <= lane_stamp[winner];
              rr_ptr    <= winner;
            end else begin
              state     <= S_EMPTY;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_EMPTY;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a scoreboard of expected events.
module tb_button_event_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  rise;
  logic        tick;
  logic        clear_drops;
  logic        evt_ready;
  logic        evt_valid;
  logic [1:0]  evt_lane;
  logic [15:0] evt_stamp;
  logic [7:0]  drop_count;

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] stamp;
  } evt_t;

  evt_t        sb[$];
  evt_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cnt;

  always #5 clock = ~clock;

  button_event_arbiter #(.NUM_LANES(4), .STAMP_BITS(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rise        (rise),
    .tick        (tick),
    .clear_drops (clear_drops),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_lane    (evt_lane),
    .evt_stamp   (evt_stamp),
    .drop_count  (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] l, input logic [15:0] s);
    evt_t e;
    e.lane  = l;
    e.stamp = s;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; the model counter follows tick.
  task automatic step(input logic [3:0] r, input logic t, input logic rdy, input logic clr);
    rise        = r;
    tick        = t;
    evt_ready   = rdy;
    clear_drops = clr;
    @(posedge clock);
    if (t) cnt = cnt + 16'd1;
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_lane", evt_lane, 0);
    chk("rst_stamp", evt_stamp, 0);
    chk("rst_drops", drop_count, 0);
    #2;
    reset_n = 1'b1;
    cnt = '0;
  endtask

  // Scoreboard consumer: an accepted event must match the queue head.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_lane", evt_lane, mon_e.lane);
        chk("sb_stamp", evt_stamp, mon_e.stamp);
      end
    end
  end

  initial begin
    reset_n = 1'b0; rise = '0; tick = 1'b0; evt_ready = 1'b0; clear_drops = 1'b0;
    cnt = '0;
    #3;
    chk("init_valid", evt_valid, 0);
    chk("init_lane", evt_lane, 0);
    chk("init_stamp", evt_stamp, 0);
    chk("init_drops", drop_count, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single event: counter at 5, lane 2, two-edge latency, one cycle valid.
    repeat (5) step(4'b0000, 1'b1, 1'b1, 1'b0);
    expect_evt(2'd2, cnt);
    step(4'b0100, 1'b0, 1'b1, 1'b0);
    chk("single_lat_e0", evt_valid, 0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("single_valid", evt_valid, 1);
    chk("single_lane", evt_lane, 2);
    chk("single_stamp", evt_stamp, 5);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("single_one_cycle", evt_valid, 0);

    // Round robin: lane 1 alone, then 1101 gives 2, 3, 0.
    expect_evt(2'd1, cnt);
    step(4'b0010, 1'b1, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b1, 1'b0);
    expect_evt(2'd2, cnt);
    expect_evt(2'd3, cnt);
    expect_evt(2'd0, cnt);
    step(4'b1101, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rr_first", evt_lane, 2);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rr_second", evt_lane, 3);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rr_third", evt_lane, 0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rr_drained", evt_valid, 0);

    // Backpressure: lane 1 at counters 7, 9, 12 with ready low.
    while (cnt != 16'd7) step(4'b0000, 1'b1, 1'b0, 1'b0);
    expect_evt(2'd1, 16'd7);
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    expect_evt(2'd1, 16'd9);
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    while (cnt != 16'd12) step(4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("bp_drops", drop_count, 1);
    repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_valid", evt_valid, 1);
    chk("bp_hold_lane", evt_lane, 1);
    chk("bp_hold_stamp", evt_stamp, 7);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("bp_next_stamp", evt_stamp, 9);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("bp_drained", evt_valid, 0);

    // Saturation and clear.
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("clr_before_sat", drop_count, 0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("sat_first3", drop_count, 3);
    repeat (60) step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("sat_243", drop_count, 243);
    repeat (15) step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("sat_255", drop_count, 255);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    chk("sat_clear_prio", drop_count, 0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("sat_resume", drop_count, 4);
    chk("sat_valid_held", evt_valid, 1);

    // Reset mid-operation discards presented and pending events.
    reset_pulse();
    repeat (4) step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", evt_valid, 0);
    chk("post_rst_drops", drop_count, 0);

    // Re-arm on the edge lane 3 is loaded.
    expect_evt(2'd3, cnt);
    step(4'b1000, 1'b1, 1'b1, 1'b0);
    expect_evt(2'd3, cnt);
    step(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("rearm_valid", evt_valid, 1);
    chk("rearm_first_stamp", evt_stamp, 0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rearm_second_lane", evt_lane, 3);
    chk("rearm_second_stamp", evt_stamp, 1);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rearm_drained", evt_valid, 0);
    chk("rearm_no_drop", drop_count, 0);

    // Counter wrap: next stamp after wrapping is 0.
    while (cnt != 16'd0) step(4'b0000, 1'b1, 1'b1, 1'b0);
    expect_evt(2'd0, 16'd0);
    step(4'b0001, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("wrap_stamp", evt_stamp, 0);
    repeat (3) step(4'b0000, 1'b0, 1'b1, 1'b0);

    chk("sb_all_seen", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
